pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipelined CPU. It sits beside the forwarding unit and handles the hazards that forwarding cannot cover:

- load-use bubbles;
- taken-branch squashes resolved in EX;
- multi-cycle multiply occupancy of EX;
- data-memory wait freezes.

It drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Rev     : 1.0  initial release
// ============================================================================
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_e;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  function automatic logic load_use_hazard(
    input logic                  mem_read,
    input logic                  reg_write,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  uses_rs2
  );
    return mem_read & reg_write & (rd != REG_ZERO) &
           ((rd == rs1) | (uses_rs2 & (rd == rs2)));
  endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Enabled up-counter that sticks at all-ones. Built only when
//           HAZARD_STATS_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`ifdef HAZARD_STATS_EN
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter
`endif
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush sequencer for load-use, branch, multiply and memory-
//           wait hazards. Statistics counters exist only under HAZARD_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int STAT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_ifid,
  input  logic [REG_ADDR_W-1:0] Rs2_ifid,
  input  logic                  uses_rs2_ifid,
  input  logic                  mem_read_idex,
  input  logic                  reg_write_en_idex,
  input  logic [REG_ADDR_W-1:0] Rd_idex,
  input  logic                  branch_taken_ex,
  input  logic                  mul_start_ex,
  input  logic                  mem_stall,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_write_en,
  output logic                  idex_flush,
  output logic                  exmem_bubble,
  output logic                  mul_busy,
  output logic                  mul_done,
  output logic [STAT_W-1:0]     stall_cycles,
  output logic [STAT_W-1:0]     flush_events
);

  // Start cycle plus the counted-down cycles give MUL_LATENCY-1 stalls.
  localparam logic [3:0] MUL_CNT_INIT = 4'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);
  localparam logic       MUL_SINGLE   = (MUL_LATENCY == 1);

  hz_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       w_load_use;

  assign w_load_use = load_use_hazard(mem_read_idex, reg_write_en_idex, Rd_idex,
                                      Rs1_ifid, Rs2_ifid, uses_rs2_ifid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!mem_stall && !branch_taken_ex && mul_start_ex && !MUL_SINGLE) begin
          state_d = MUL_BUSY;
          cnt_d   = MUL_CNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (!mem_stall) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_write_en = 1'b1;
    idex_flush    = 1'b0;
    exmem_bubble  = 1'b0;
    mul_busy      = 1'b0;
    mul_done      = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
          end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (mul_start_ex) begin
            if (MUL_SINGLE) begin
              mul_done = 1'b1;
            end else begin
              pc_write_en   = 1'b0;
              ifid_write_en = 1'b0;
              idex_write_en = 1'b0;
              exmem_bubble  = 1'b1;
            end
          end else if (w_load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
          end
        end
        MUL_BUSY: begin
          mul_busy = 1'b1;
          if (mem_stall) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
          end else if (cnt_q != 4'd0) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
            exmem_bubble  = 1'b1;
          end else begin
            mul_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // PC is held exactly on load-use, multiply and memory-wait cycles; drop the latter.
  sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (~pc_write_en & ~mem_stall),
    .count_o (stall_cycles)
  );

  sat_counter #(.WIDTH(STAT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ifid_flush),
    .count_o (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule : pipeline_hazard_ctrl
`default_nettype wire
